// File: rtl/limn2600_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache for the Limn2600 CPU port.
// One word per line; single outstanding memory request; sweep-based flush.
module limn2600_dm_cache #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_BITS  = 8,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  input  logic                   flush_req,
  output logic                   mem_req_valid,
  input  logic                   mem_req_ready,
  output logic                   mem_we,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0]  mem_wdata,
  input  logic                   mem_resp_valid,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  output logic [COUNT_WIDTH-1:0] hit_count,
  output logic [COUNT_WIDTH-1:0] miss_count
);

  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

  typedef enum logic [2:0] {
    FLUSH, IDLE, LOOKUP, MEM_RD, MEM_WAIT, MEM_WR
  } state_t;

  state_t                  state;
  logic [INDEX_BITS-1:0]   ctr;
  logic                    flush_pend;
  logic [LINES-1:0]        valid;
  logic [DATA_WIDTH-1:0]   data_mem [LINES];
  logic [TAG_W-1:0]        tag_mem  [LINES];

  logic                    r_we;
  logic [ADDR_WIDTH-3:0]   r_word;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic [INDEX_BITS-1:0]   idx;
  logic [TAG_W-1:0]        r_tag;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic                    hit;
  logic                    unused_addr_lsbs;

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  assign unused_addr_lsbs = ^req_addr[1:0];
  assign idx       = r_word[INDEX_BITS-1:0];
  assign r_tag     = r_word[ADDR_WIDTH-3:INDEX_BITS];
  assign word_addr = {r_word, 2'b00};
  assign hit       = valid[idx] && (tag_mem[idx] == r_tag);
  assign req_ready = (state == IDLE) && !flush_req && !flush_pend;

  // Request capture: data path only, no reset needed
  always_ff @(posedge clk) begin
    if (req_valid && req_ready) begin
      r_we    <= req_we;
      r_word  <= req_addr[ADDR_WIDTH-1:2];
      r_wdata <= req_wdata;
    end
  end

  // Line storage; write hits update data only, refills also replace the tag
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == LOOKUP && r_we && hit) begin
        data_mem[idx] <= r_wdata;
      end else if (state == MEM_WAIT && mem_resp_valid) begin
        data_mem[idx] <= mem_rdata;
        tag_mem[idx]  <= r_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FLUSH;
      ctr           <= '0;
      flush_pend    <= 1'b0;
      resp_valid    <= 1'b0;
      resp_rdata    <= '0;
      mem_req_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (flush_req && state != FLUSH && state != IDLE) flush_pend <= 1'b1;
      case (state)
        FLUSH: begin
          valid[ctr] <= 1'b0;
          ctr        <= ctr + 1'b1;
          if (&ctr) state <= IDLE;
        end
        IDLE: begin
          if (flush_req || flush_pend) begin
            state      <= FLUSH;
            ctr        <= '0;
            flush_pend <= 1'b0;
          end else if (req_valid) begin
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) hit_count  <= sat_inc(hit_count);
          else     miss_count <= sat_inc(miss_count);
          if (r_we) begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b1;
            mem_addr      <= word_addr;
            mem_wdata     <= r_wdata;
            state         <= MEM_WR;
          end else if (hit) begin
            resp_valid <= 1'b1;
            resp_rdata <= data_mem[idx];
            state      <= IDLE;
          end else begin
            mem_req_valid <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= word_addr;
            state         <= MEM_RD;
          end
        end
        MEM_RD: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            state         <= MEM_WAIT;
          end
        end
        MEM_WAIT: begin
          if (mem_resp_valid) begin
            valid[idx] <= 1'b1;
            resp_valid <= 1'b1;
            resp_rdata <= mem_rdata;
            state      <= IDLE;
          end
        end
        MEM_WR: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            resp_valid    <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule
